// File: rtl/timer_irq_if.sv
// Signal bundle between the timer peripheral / CSR file and the machine-timer
// interrupt generator. The master drives the time base and compare; the slave returns MTIP/IRQ.
interface timer_irq_if;
  logic [63:0] cycle_in;
  logic [63:0] mtimecmp_in;
  logic        mtimecmp_write_in;
  logic        mtie_in;
  logic        mtip_out;
  logic        irq_out;
  logic        fire_pulse_out;

  modport master (
    output cycle_in,
    output mtimecmp_in,
    output mtimecmp_write_in,
    output mtie_in,
    input  mtip_out,
    input  irq_out,
    input  fire_pulse_out
  );

  modport slave (
    input  cycle_in,
    input  mtimecmp_in,
    input  mtimecmp_write_in,
    input  mtie_in,
    output mtip_out,
    output irq_out,
    output fire_pulse_out
  );
endinterface

// File: rtl/timer_irq.sv
// Machine-timer interrupt generator: a two-stage 64-bit compare of cycle vs mtimecmp,
// with a holdoff window after every mtimecmp write so a half-written compare never fires.
module timer_irq (
  input  logic        clk,
  input  logic        reset,
  timer_irq_if.slave  bus
);

  localparam logic [1:0] HOLDOFF_LOAD = 2'd2;

  logic       hi_gt_q;
  logic       hi_eq_q;
  logic       lo_ge_q;
  logic [1:0] hold_cnt_q;
  logic       mtip_q;
  logic       irq_q;
  logic       fire_q;

  logic       ge;
  logic       hold_tc;
  logic       mtip_next;

  assign ge      = hi_gt_q | (hi_eq_q & lo_ge_q);
  assign hold_tc = (hold_cnt_q == 2'd0);

  // Holdoff forces MTIP low on the write edge itself and while the counter is still running.
  always_comb begin
    mtip_next = 1'b0;
    if (!reset && !bus.mtimecmp_write_in && hold_tc) begin
      mtip_next = ge;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_gt_q    <= 1'b0;
      hi_eq_q    <= 1'b0;
      lo_ge_q    <= 1'b0;
      hold_cnt_q <= HOLDOFF_LOAD;
      mtip_q     <= 1'b0;
      irq_q      <= 1'b0;
      fire_q     <= 1'b0;
    end else begin
      hi_gt_q <= (bus.cycle_in[63:32] >  bus.mtimecmp_in[63:32]);
      hi_eq_q <= (bus.cycle_in[63:32] == bus.mtimecmp_in[63:32]);
      lo_ge_q <= (bus.cycle_in[31:0]  >= bus.mtimecmp_in[31:0]);

      if (bus.mtimecmp_write_in) begin
        hold_cnt_q <= HOLDOFF_LOAD;
      end else if (!hold_tc) begin
        hold_cnt_q <= hold_cnt_q - 2'd1;
      end

      mtip_q <= mtip_next;
      irq_q  <= mtip_next & bus.mtie_in;
      fire_q <= mtip_next & ~mtip_q;
    end
  end

  assign bus.mtip_out       = mtip_q;
  assign bus.irq_out        = irq_q;
  assign bus.fire_pulse_out = fire_q;

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: directed scenarios plus a randomized run, all
// checked against a cycle-history model of the MTIP/IRQ/fire rules.
module tb_timer_irq;

  localparam int MAXC = 4096;

  logic clk;
  logic reset;
  timer_irq_if bus ();

  timer_irq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int k;

  logic        rst_h [MAXC];
  logic        wr_h  [MAXC];
  logic        tie_h [MAXC];
  logic        exp_h [MAXC];
  logic [63:0] cyc_h [MAXC];
  logic [63:0] cmp_h [MAXC];

  logic exp_mtip;
  logic exp_irq;
  logic exp_fire;

  // MTIP in cycle n is low if a reset or write occurred in any of the three preceding
  // cycles; otherwise it is the full 64-bit compare of the inputs two cycles earlier.
  function automatic logic model_mtip(int n);
    if (n < 3) return 1'b0;
    for (int j = n - 3; j < n; j++) begin
      if (rst_h[j] || wr_h[j]) return 1'b0;
    end
    return (cyc_h[n-2] >= cmp_h[n-2]);
  endfunction

  task automatic tick();
    rst_h[k] = reset;
    wr_h[k]  = bus.mtimecmp_write_in;
    tie_h[k] = bus.mtie_in;
    cyc_h[k] = bus.cycle_in;
    cmp_h[k] = bus.mtimecmp_in;
    @(posedge clk);
    #1;
    k++;
    exp_mtip = model_mtip(k);
    exp_h[k] = exp_mtip;
    exp_irq  = exp_mtip & tie_h[k-1];
    exp_fire = exp_mtip & ~exp_h[k-1];
  endtask

  task automatic test_reset();
    int fires;
    reset = 1'b1;
    bus.cycle_in = 64'd0;
    bus.mtimecmp_in = 64'd0;
    bus.mtimecmp_write_in = 1'b0;
    bus.mtie_in = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.mtip_out, bus.irq_out, bus.fire_pulse_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state k=%0d got=%b exp=000", k,
               {bus.mtip_out, bus.irq_out, bus.fire_pulse_out});
    end
    reset = 1'b0;
    fires = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.mtip_out, bus.irq_out, bus.fire_pulse_out} !== {exp_mtip, exp_irq, exp_fire}) begin
        errors++;
        $display("FAIL reset_zero_model k=%0d got=%b exp=%b", k,
                 {bus.mtip_out, bus.irq_out, bus.fire_pulse_out}, {exp_mtip, exp_irq, exp_fire});
      end
      checks++;
      if (bus.mtip_out !== (i >= 3)) begin
        errors++;
        $display("FAIL reset_zero_mtip r+%0d got=%b exp=%b", i, bus.mtip_out, (i >= 3));
      end
      if (bus.fire_pulse_out === 1'b1) fires++;
      bus.cycle_in = bus.cycle_in + 64'd1;
      tick();
    end
    checks++;
    if (fires != 1) begin
      errors++;
      $display("FAIL reset_zero_fire_count got=%0d exp=1", fires);
    end
  endtask

  task automatic test_exact_match();
    bus.mtimecmp_in = 64'd100;
    bus.mtimecmp_write_in = 1'b1;
    bus.cycle_in = 64'd90;
    tick();
    bus.mtimecmp_write_in = 1'b0;
    for (int c = 91; c <= 110; c++) begin
      bus.cycle_in = 64'(c);
      checks++;
      if ({bus.mtip_out, bus.irq_out, bus.fire_pulse_out} !== {exp_mtip, exp_irq, exp_fire}) begin
        errors++;
        $display("FAIL exact_model k=%0d got=%b exp=%b", k,
                 {bus.mtip_out, bus.irq_out, bus.fire_pulse_out}, {exp_mtip, exp_irq, exp_fire});
      end
      if (c >= 94) begin
        checks++;
        if (bus.mtip_out !== (c >= 102)) begin
          errors++;
          $display("FAIL exact_mtip cycle=%0d got=%b exp=%b", c, bus.mtip_out, (c >= 102));
        end
      end
      tick();
    end
  endtask

  task automatic test_hi_carry();
    logic [63:0] seq [6];
    seq[0] = 64'h0_FFFF_FFFE;
    seq[1] = 64'h0_FFFF_FFFF;
    seq[2] = 64'h1_0000_0000;
    seq[3] = 64'h1_0000_0000;
    seq[4] = 64'h1_0000_0000;
    seq[5] = 64'h1_0000_0000;
    bus.mtimecmp_in = 64'h1_0000_0000;
    bus.mtimecmp_write_in = 1'b1;
    bus.cycle_in = 64'h0_FFFF_FFF0;
    tick();
    bus.mtimecmp_write_in = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      bus.cycle_in = seq[i];
      checks++;
      if (bus.mtip_out !== (i >= 4) || bus.mtip_out !== exp_mtip) begin
        errors++;
        $display("FAIL hi_carry step=%0d got=%b exp=%b model=%b", i, bus.mtip_out, (i >= 4), exp_mtip);
      end
      tick();
    end
    bus.mtimecmp_in = 64'h0_FFFF_FFFF;
    bus.mtimecmp_write_in = 1'b1;
    bus.cycle_in = 64'h1_0000_0000;
    tick();
    bus.mtimecmp_write_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.mtip_out !== 1'b1 || bus.mtip_out !== exp_mtip) begin
      errors++;
      $display("FAIL hi_gt_path got=%b exp=1 model=%b", bus.mtip_out, exp_mtip);
    end
  endtask

  task automatic test_write_holdoff();
    bus.mtimecmp_in = 64'h100;
    bus.mtimecmp_write_in = 1'b1;
    bus.cycle_in = 64'h1000;
    tick();
    bus.mtimecmp_write_in = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus.mtip_out !== 1'b1) begin
      errors++;
      $display("FAIL holdoff_setup got=%b exp=1", bus.mtip_out);
    end
    bus.mtimecmp_write_in = 1'b1;
    bus.mtimecmp_in = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.mtimecmp_write_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.mtip_out !== 1'b0 || bus.mtip_out !== exp_mtip) begin
        errors++;
        $display("FAIL holdoff_raise t+%0d got=%b exp=0", i, bus.mtip_out);
      end
      tick();
    end
    bus.mtimecmp_write_in = 1'b1;
    bus.mtimecmp_in = 64'h800;
    tick();
    bus.mtimecmp_write_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if ({bus.mtip_out, bus.fire_pulse_out} !== {(i >= 4), (i == 4)} ||
          {bus.mtip_out, bus.fire_pulse_out} !== {exp_mtip, exp_fire}) begin
        errors++;
        $display("FAIL holdoff_lower t+%0d got mtip/fire=%b exp=%b", i,
                 {bus.mtip_out, bus.fire_pulse_out}, {(i >= 4), (i == 4)});
      end
      tick();
    end
  endtask

  task automatic test_split_write();
    bus.mtimecmp_in = 64'd0;
    bus.mtimecmp_write_in = 1'b1;
    bus.cycle_in = 64'h5_0000_0000;
    tick();
    bus.mtimecmp_write_in = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus.mtip_out !== 1'b1) begin
      errors++;
      $display("FAIL split_setup got=%b exp=1", bus.mtip_out);
    end
    bus.mtimecmp_write_in = 1'b1;
    tick();
    bus.mtimecmp_in = 64'h0_0000_0010;
    tick();
    bus.mtimecmp_write_in = 1'b0;
    bus.mtimecmp_in = 64'h9_0000_0010;
    for (int i = 2; i <= 8; i++) begin
      checks++;
      if ({bus.mtip_out, bus.fire_pulse_out} !== 2'b00 ||
          {bus.mtip_out, bus.fire_pulse_out} !== {exp_mtip, exp_fire}) begin
        errors++;
        $display("FAIL split_write t+%0d got mtip/fire=%b exp=00", i,
                 {bus.mtip_out, bus.fire_pulse_out});
      end
      tick();
    end
  endtask

  task automatic test_mtie_gating();
    logic m;
    bus.mtimecmp_in = 64'd0;
    bus.mtimecmp_write_in = 1'b1;
    bus.cycle_in = 64'd1000;
    bus.mtie_in = 1'b1;
    tick();
    bus.mtimecmp_write_in = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      bus.mtie_in = m;
      tick();
      checks++;
      if ({bus.mtip_out, bus.irq_out} !== {1'b1, m} ||
          {bus.mtip_out, bus.irq_out, bus.fire_pulse_out} !== {exp_mtip, exp_irq, exp_fire}) begin
        errors++;
        $display("FAIL mtie_gating step=%0d got mtip/irq=%b exp=%b", i,
                 {bus.mtip_out, bus.irq_out}, {1'b1, m});
      end
    end
  endtask

  task automatic test_midrun_reset();
    bus.mtie_in = 1'b1;
    tick();
    checks++;
    if (bus.mtip_out !== 1'b1) begin
      errors++;
      $display("FAIL midrun_setup got=%b exp=1", bus.mtip_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.mtip_out, bus.irq_out, bus.fire_pulse_out} !== 3'b000) begin
      errors++;
      $display("FAIL midrun_reset_outputs got=%b exp=000",
               {bus.mtip_out, bus.irq_out, bus.fire_pulse_out});
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.mtip_out !== (i >= 3) ||
          {bus.mtip_out, bus.irq_out, bus.fire_pulse_out} !== {exp_mtip, exp_irq, exp_fire}) begin
        errors++;
        $display("FAIL midrun_holdoff r+%0d got=%b exp=%b", i,
                 {bus.mtip_out, bus.irq_out, bus.fire_pulse_out}, {exp_mtip, exp_irq, exp_fire});
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [63:0] cnt;
    logic [63:0] new_cmp;
    logic        pending;
    int          r;
    cnt = 64'h0_FFFF_FF00;
    bus.cycle_in = cnt;
    bus.mtimecmp_in = cnt + 64'd10;
    bus.mtimecmp_write_in = 1'b1;
    tick();
    pending = 1'b0;
    new_cmp = 64'd0;
    for (int n = 0; n < 1500; n++) begin
      bus.mtimecmp_write_in = 1'b0;
      reset = 1'b0;
      if (pending) begin
        bus.mtimecmp_in = new_cmp;
        pending = 1'b0;
      end
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        reset = 1'b1;
      end else if (r < 25) begin
        bus.mtimecmp_write_in = 1'b1;
        pending = 1'b1;
        new_cmp = cnt + 64'($urandom_range(0, 90)) - 64'd30;
      end
      if ($urandom_range(0, 9) == 0) bus.mtie_in = ~bus.mtie_in;
      cnt = cnt + 64'($urandom_range(0, 3));
      bus.cycle_in = cnt;
      tick();
      checks++;
      if ({bus.mtip_out, bus.irq_out, bus.fire_pulse_out} !== {exp_mtip, exp_irq, exp_fire}) begin
        errors++;
        $display("FAIL random k=%0d got=%b exp=%b", k,
                 {bus.mtip_out, bus.irq_out, bus.fire_pulse_out}, {exp_mtip, exp_irq, exp_fire});
      end
    end
    reset = 1'b0;
    bus.mtimecmp_write_in = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    k = 0;
    exp_h[0] = 1'b0;
    exp_mtip = 1'b0;
    exp_irq = 1'b0;
    exp_fire = 1'b0;
    test_reset();
    test_exact_match();
    test_hi_carry();
    test_write_holdoff();
    test_split_write();
    test_mtie_gating();
    test_midrun_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
# timer_irq

Machine-timer interrupt generator sitting directly downstream of the memory-mapped timer peripheral. It takes the core's 64-bit cycle count and the timer's 64-bit `mtimecmp` value, performs a pipelined unsigned 64-bit compare in two 32-bit halves, and drives the `mip.MTIP` level to the CSR/trap unit. Every `mtimecmp` write triggers a holdoff window, so a half-updated compare value can never raise a spurious interrupt.

## Interface

- No parameters. Widths are fixed: 64-bit time base, two 32-bit compare halves.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `cycle_in`  in  64  free-running cycle count (same value the timer returns as `mtime`).
- `mtimecmp_in`  in  64  current `mtimecmp` register contents from the timer.
- `mtimecmp_write_in`  in  1  one-cycle pulse: the timer is writing either half of `mtimecmp` this cycle (bus `sel` & word 2/3 & any mask bit); the new value is visible on `mtimecmp_in` the next cycle.
- `mtie_in`  in  1  `mie.MTIE` from the CSR file.
- `mtip_out`  out  1  registered `mip.MTIP` level.
- `irq_out`  out  1  registered `mtip & mtie` request to the trap unit.
- `fire_pulse_out`  out  1  one-cycle pulse on each 0→1 transition of `mtip_out` (for perf counters/debug).

## Operation

- Stage 1 (registered at each edge from the current-cycle inputs):
  - `hi_gt` = `cycle[63:32] > cmp[63:32]`
  - `hi_eq` = `cycle[63:32] == cmp[63:32]`
  - `lo_ge` = `cycle[31:0] >= cmp[31:0]`
  - All compares are unsigned.
- Stage 2: `ge = hi_gt | (hi_eq & lo_ge)`, which equals `cycle_in >= mtimecmp_in` unsigned on the full 64 bits. There is no wrap-around handling; 64-bit overflow is treated as unreachable.
- Holdoff counter `H` (2 bits):
  - On reset or on any edge where `mtimecmp_write_in`=1: `H`←2.
  - Otherwise, if `H`>0: `H`←`H`−1.
- `mtip_out` update at each edge:
  - If reset, a write this cycle, or `H`≠0 before the edge: `mtip_out`←0.
  - Otherwise: `mtip_out`←stage-2 `ge`.
- `irq_out` is registered from the same next-state values: `irq_out`←next(`mtip_out`) & `mtie_in`. It is forced to 0 whenever `mtip_out` is forced to 0.
- `fire_pulse_out`←next(`mtip_out`) & !`mtip_out`.
- A write during holdoff restarts the holdoff (`H`←2). Back-to-back writes to the low and high halves therefore produce one continuous holdoff.
- `mtip_out` is a level, not a latch. It falls 2 cycles after the compare becomes false, for example when software raises `mtimecmp` (and holdoff also forces it low).
- `mtimecmp` = 0 after reset is legal and gives MTIP=1 once holdoff ends.

## Timing

- Reset values: `mtip_out`=0, `irq_out`=0, `fire_pulse_out`=0, `H`=2, stage-1 flags=0.
- Compare latency, steady state: inputs in cycle *x* → `mtip_out` reflects them from cycle *x*+2.
- Write at cycle *t*:
  - `mtip_out`=0 during cycles *t*+1 through *t*+3.
  - From cycle *t*+4, `mtip_out` reflects the inputs of cycle *t*+2, which are post-write values.
- Reset released, first low cycle *r*:
  - `mtip_out`=0 during cycles *r* through *r*+2.
  - The first valid value appears in cycle *r*+3.
- Reset asserted mid-operation: all outputs are 0 from the next cycle, and holdoff restarts on release.
- `mtie_in` change: reaches `irq_out` after 1 cycle. It has no effect on `mtip_out`.

## Test plan

- **Reset, zero compare:** `mtimecmp`=0, `cycle` counting from 0 → `mtip_out`=0 for 3 cycles after reset release, then 1. `fire_pulse_out` is high for exactly 1 cycle.
- **Exact match:** `mtimecmp`=100, `cycle` increments each clock → `mtip_out` rises in the cycle `cycle_in`=102 and stays 1. Check `cycle`=99 still gives 0 two cycles later.
- **High-half carry:**
  - `mtimecmp`=0x1_0000_0000, `cycle` steps 0x0_FFFF_FFFE → 0x0_FFFF_FFFF → 0x1_0000_0000 → MTIP is 0 until it reflects 0x1_0000_0000.
  - `mtimecmp`=0x0_FFFF_FFFF, `cycle`=0x1_0000_0000 → 1 (`hi_gt` path).
- **Write holdoff:**
  - While MTIP=1, pulse `mtimecmp_write_in` at cycle *t* and change `mtimecmp` to 0xFFFF_FFFF_FFFF_FFFF → MTIP=0 from *t*+1 and stays 0.
  - Repeat with the new value ≤ `cycle` → MTIP is 0 for *t*+1..*t*+3, 1 at *t*+4, and `fire_pulse_out` fires at *t*+4.
- **Split write:** write the low half at *t* and the high half at *t*+1, with a transiently small intermediate value → `mtip_out` stays 0 through *t*+4, with no `fire_pulse_out` glitch.
- **MTIE gating / mid-run reset:**
  - MTIP=1 with `mtie_in` toggled 0/1 → `irq_out` follows 1 cycle later.
  - Assert `reset` for 1 cycle → all outputs 0 the next cycle, and the holdoff is re-observed.
